// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: size codes, FSM states and
// the request legality check.
package mem_access_unit_pkg;

    localparam int ADDR_DEF = 16;
    localparam int WORD_DEF = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_DATA,
        S_WR,
        S_RESP
    } state_t;

    // High when the request is misaligned for its size or uses the illegal size code.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    req_bad = 1'b0;
            SZ_H:    req_bad = lo[0];
            SZ_W:    req_bad = (lo != 2'b00);
            default: req_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the word-memory port of the load/store unit.
interface mem_access_unit_if #(
    parameter int ADDR = 16,
    parameter int WORD = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [31:0]     req_addr;
    logic [WORD-1:0] req_wdata;
    logic            resp_valid;
    logic [WORD-1:0] resp_rdata;
    logic            resp_err;
    logic [ADDR-1:0] mem_A;
    logic            mem_W;
    logic [WORD-1:0] mem_D;
    logic [WORD-1:0] mem_Q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_Q,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_W, mem_D
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_Q,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_W, mem_D
    );
endinterface

// File: rtl/mem_access_unit_lane_extract.sv
// Combinational lane logic: extends a byte/half lane of a memory word for loads
// and merges store data into the addressed lane for read-modify-write.
module mem_access_unit_lane_extract
    import mem_access_unit_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] i_word,
    input  logic [1:0]      i_lane,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [WORD-1:0] i_wdata,
    output logic [WORD-1:0] o_load,
    output logic [WORD-1:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes: byte k sits at bits [8k+7:8k].
    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load  = i_word;
        o_merge = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load  = i_unsigned ? {{(WORD-8){1'b0}}, w_byte}
                                     : {{(WORD-8){w_byte[7]}}, w_byte};
                o_merge = i_word;
                o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_load  = i_unsigned ? {{(WORD-16){1'b0}}, w_half}
                                     : {{(WORD-16){w_half[15]}}, w_half};
                o_merge = i_word;
                o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load  = i_word;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only memory: one request in flight, sub-word
// stores done as read-modify-write, load results sign/zero extended.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR = ADDR_DEF,
    parameter int WORD = WORD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_t          r_state;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [1:0]      r_lane;
    logic [ADDR-1:0] r_mem_A;
    logic [WORD-1:0] r_mem_D;
    logic [WORD-1:0] r_rdata;
    logic            r_err;

    logic            w_bad;
    logic [WORD-1:0] w_load;
    logic [WORD-1:0] w_merge;
    logic            w_unused_addr_hi;

    assign w_bad            = req_bad(bus.req_size, bus.req_addr[1:0]);
    assign w_unused_addr_hi = ^bus.req_addr[31:ADDR+2];

    // r_mem_D doubles as the latched store data until DATA overwrites it with the merge.
    mem_access_unit_lane_extract #(.WORD(WORD)) u_lane (
        .i_word     (bus.mem_Q),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_mem_D),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_lane  <= 2'b00;
            r_mem_A <= '0;
            r_mem_D <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_size  <= bus.req_size;
                        r_uns   <= bus.req_unsigned;
                        r_lane  <= bus.req_addr[1:0];
                        r_mem_A <= bus.req_addr[ADDR+1:2];
                        r_mem_D <= bus.req_wdata;
                        if (w_bad) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (bus.req_we && bus.req_size == SZ_W) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD:   r_state <= S_DATA;
                S_DATA: begin
                    if (r_we) begin
                        r_mem_D <= w_merge;
                        r_state <= S_WR;
                    end else begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The write strobe is gated by rst so a reset in WR leaves memory untouched.
    assign bus.mem_W      = (r_state == S_WR) & ~rst;
    assign bus.mem_A      = r_mem_A;
    assign bus.mem_D      = r_mem_D;
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: registered word memory, timing-table reference model
// checked every cycle, directed literal cases and randomized traffic.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clear = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if #(.ADDR(16), .WORD(32)) bus ();

    mem_access_unit #(.ADDR(16), .WORD(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word memory with one-cycle registered read
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
            bus.mem_Q <= 32'h0;
        end else begin
            if (bus.mem_W) mem[bus.mem_A[7:0]] <= bus.mem_D;
            bus.mem_Q <= mem[bus.mem_A[7:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Literal expectations supplied by the stimulus for selected requests
    logic        lit_en = 1'b0;
    logic [31:0] lit_rd = 32'h0;
    logic        lit_err = 1'b0;
    int          lit_lat = 0;
    logic        lit_wen = 1'b0;
    logic [31:0] lit_wd = 32'h0;
    logic [15:0] lit_wa = 16'h0;
    logic        lit_gap_en = 1'b0;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic        busy = 1'b0;
    int          acc = 0;
    int          prev_acc = 0;
    int          lat = 0;
    int          wc = 0;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_wd = 32'h0;
    logic [7:0]  exp_idx = 8'h0;
    logic [15:0] exp_A = 16'h0;
    logic [31:0] last_rd = 32'h0;
    logic        last_err = 1'b0;
    logic        rst_prev = 1'b1;

    always @(negedge clk) begin
        int c;
        logic exp_ready, exp_resp, exp_w, bad;
        logic [31:0] a, word, v, m;
        int sh;
        c = cyc;
        if (mem_clear)
            for (int i = 0; i < 256; i++) ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
        if (c >= 1) begin
            exp_ready = !busy;
            exp_resp  = busy && (c == acc + lat);
            exp_w     = busy && (wc > 0) && (c == acc + wc) && !rst;
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
            chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, exp_resp});
            chk("mem_W", {31'b0, bus.mem_W}, {31'b0, exp_w});
            chk("mem_A", {16'b0, bus.mem_A}, {16'b0, exp_A});
            if (rst_prev) chk("mem_D_after_reset", bus.mem_D, 32'h0);
            if (exp_w) begin
                chk("mem_D", bus.mem_D, exp_wd);
                ref_mem[exp_idx] = exp_wd;
                if (lit_wen) begin
                    chk("lit_mem_D", bus.mem_D, lit_wd);
                    chk("lit_mem_A", {16'b0, bus.mem_A}, {16'b0, lit_wa});
                    chk("lit_write_cycle", c - acc, 3);
                end
            end
            if (exp_resp) begin
                last_rd  = exp_rd;
                last_err = exp_err;
                busy     = 1'b0;
                if (lit_en) begin
                    chk("lit_rdata", bus.resp_rdata, lit_rd);
                    chk("lit_err", {31'b0, bus.resp_err}, {31'b0, lit_err});
                    chk("lit_latency", c - acc, lit_lat);
                end
            end
            chk("resp_rdata", bus.resp_rdata, last_rd);
            chk("resp_err", {31'b0, bus.resp_err}, {31'b0, last_err});
            if (rst) begin
                busy     = 1'b0;
                exp_A    = 16'h0;
                last_rd  = 32'h0;
                last_err = 1'b0;
            end else if (exp_ready && bus.req_valid) begin
                if (lit_gap_en) chk("accept_gap", c - prev_acc, 4);
                prev_acc = c;
                a       = bus.req_addr;
                exp_A   = a[17:2];
                exp_idx = a[9:2];
                word    = ref_mem[a[9:2]];
                sh      = 8 * int'(a[1:0]);
                bad     = (bus.req_size == 2'b11) ||
                          (bus.req_size == 2'b01 && a[0]) ||
                          (bus.req_size == 2'b10 && a[1:0] != 2'b00);
                busy = 1'b1;
                acc  = c;
                wc   = 0;
                exp_rd  = 32'h0;
                exp_err = 1'b0;
                m = (bus.req_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
                if (bad) begin
                    lat     = 1;
                    exp_err = 1'b1;
                end else if (!bus.req_we) begin
                    lat = 3;
                    if (bus.req_size == 2'b10) begin
                        exp_rd = word;
                    end else begin
                        v = (word >> sh) & m;
                        if (!bus.req_unsigned && ((bus.req_size == 2'b00) ? v[7] : v[15]))
                            v = v | ~m;
                        exp_rd = v;
                    end
                end else if (bus.req_size == 2'b10) begin
                    lat    = 2;
                    wc     = 1;
                    exp_wd = bus.req_wdata;
                end else begin
                    lat    = 4;
                    wc     = 3;
                    exp_wd = (word & ~(m << sh)) | ((bus.req_wdata << sh) & (m << sh));
                end
            end
        end
        rst_prev = rst;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            n++;
            if (n > 20) begin
                $display("FAIL req_ready_timeout at cycle %0d: got 0 expected 1", cyc);
                $fatal(1, "bench stopped");
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        @(negedge clk);
        while (!bus.resp_valid) begin
            n++;
            if (n > 10) begin
                $display("FAIL resp_valid_timeout at cycle %0d: got 0 expected 1", cyc);
                $fatal(1, "bench stopped");
            end
            @(negedge clk);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic lit, input logic [31:0] lrd, input logic lerr,
                          input int llat);
        lit_en           = lit;
        lit_rd           = lrd;
        lit_err          = lerr;
        lit_lat          = llat;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] sz;
        int r;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Word store/load and extension cases
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF1234, 1'b1, 32'h0, 1'b0, 2);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 3);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0, 3);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, 3);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 32'h000080FF, 1'b0, 3);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 32'h00000034, 1'b0, 3);
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 3);

        // Byte store read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1, 32'h0, 1'b0, 2);
        lit_wen = 1'b1; lit_wd = 32'h1122AA44; lit_wa = 16'h0004;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b1, 32'h0, 1'b0, 4);
        lit_wen = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1122AA44, 1'b0, 3);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFC0010, 32'h0, 1'b1, 32'h1122AA44, 1'b0, 3);

        // Errors
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        do_req(1'b1, 2'b10, 1'b0, 32'h02, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1);

        // Back-to-back loads with req_valid held
        lit_en           = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_valid    = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        lit_gap_en   = 1'b1;
        bus.req_addr = 32'h14;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lit_gap_en    = 1'b0;
        wait_resp();
        @(posedge clk); #1;

        // Reset during WR of a byte store
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1, 32'h0, 1'b0, 2);
        lit_en        = 1'b0;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h11;
        bus.req_wdata = 32'h00000055;
        bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11223344, 1'b0, 3);

        // Reset wins over a same-cycle request
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_valid = 1'b1;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   {$urandom_range(0, 32'h3FFFFF), 10'($urandom_range(0, 1023))},
                   $urandom, 1'b0, 32'h0, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
